// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the inverter-chain TDC: arm, settle, sample, average, hand off.
// Optional feature macro TDC_BUBBLE_FIX_EN selects a bubble-tolerant first-zero tap count.
module tdc_meas_ctrl #(
    parameter int N_TAPS        = 16,
    parameter int LOG2_SAMPLES  = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int RES_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              cont_i,
    input  logic [N_TAPS-1:0] taps_i,
    output logic              sensor_en_o,
    output logic              busy_o,
    output logic [RES_W-1:0]  result_o,
    output logic              range_o,
    output logic              valid_o,
    input  logic              ready_i
);

    localparam int CW      = $clog2(N_TAPS + 1);
    localparam int NS      = 1 << LOG2_SAMPLES;
    localparam int ACC_W   = CW + LOG2_SAMPLES;
    localparam int HALF    = (LOG2_SAMPLES > 0) ? (1 << (LOG2_SAMPLES - 1)) : 0;
    localparam int CNT_MAX = (SETTLE_CYCLES > NS) ? SETTLE_CYCLES : NS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_SAMPLE = 3'd2,
        S_CALC   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_TAPS-1:0] r_sync [SYNC_STAGES];
    logic [ACC_W-1:0]  r_acc;
    logic              r_range;
    logic [RES_W-1:0]  r_result;
    logic              r_sensor_en;
    logic              r_busy;
    logic              r_valid;
    logic              w_req;
    logic              w_extreme;
    logic [CW-1:0]     w_sample;
    logic [ACC_W:0]    w_sum;
    logic [CW-1:0]     w_avg;

    // Tap count of one synchronised sample (thermometer code to integer).
    function automatic logic [CW-1:0] f_tap_count(input logic [N_TAPS-1:0] taps);
        logic [CW-1:0] cnt;
`ifdef TDC_BUBBLE_FIX_EN
        logic          run;
        run = 1'b1;
`endif
        cnt = {CW{1'b0}};
        for (int i = 0; i < N_TAPS; i++) begin
`ifdef TDC_BUBBLE_FIX_EN
            if (run && taps[i]) begin
                cnt = cnt + CW'(1);
            end else begin
                run = 1'b0;
            end
`else
            if (taps[i]) begin
                cnt = cnt + CW'(1);
            end else begin
                cnt = cnt;
            end
`endif
        end
        return cnt;
    endfunction

    assign w_req     = start_i | cont_i;
    assign w_sample  = f_tap_count(r_sync[SYNC_STAGES-1]);
    assign w_extreme = (r_sync[SYNC_STAGES-1] == {N_TAPS{1'b0}}) ||
                       (r_sync[SYNC_STAGES-1] == {N_TAPS{1'b1}});
    // Round half up before dropping the fractional sample bits.
    assign w_sum     = {1'b0, r_acc} + (ACC_W + 1)'(HALF);
    assign w_avg     = CW'(w_sum >> LOG2_SAMPLES);

    // Next-state decode for the measurement sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = S_ARM;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ARM: begin
                if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    w_next = S_SAMPLE;
                end else begin
                    w_next = S_ARM;
                end
            end
            S_SAMPLE: begin
                if (r_cnt == CNT_W'(NS - 1)) begin
                    w_next = S_CALC;
                end else begin
                    w_next = S_SAMPLE;
                end
            end
            S_CALC: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                if (ready_i) begin
                    w_next = w_req ? S_ARM : S_IDLE;
                end else begin
                    w_next = S_DONE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register and outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sensor_en <= 1'b0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_sensor_en <= (w_next == S_ARM) || (w_next == S_SAMPLE);
            r_busy      <= (w_next != S_IDLE);
            r_valid     <= (w_next == S_DONE);
        end
    end

    // Phase counter: restarts on every state change, runs only in ARM/SAMPLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_next != r_state) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if ((r_state == S_ARM) || (r_state == S_SAMPLE)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= {CNT_W{1'b0}};
        end
    end

    // Tap synchroniser; ARM lasts long enough to flush stale taps out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= {N_TAPS{1'b0}};
            end
        end else if ((r_state == S_ARM) || (r_state == S_SAMPLE)) begin
            r_sync[0] <= taps_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= {N_TAPS{1'b0}};
            end
        end
    end

    // Sample accumulator, cleared while arming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= {ACC_W{1'b0}};
        end else if (r_state == S_ARM) begin
            r_acc <= {ACC_W{1'b0}};
        end else if (r_state == S_SAMPLE) begin
            r_acc <= r_acc + ACC_W'(w_sample);
        end else begin
            r_acc <= r_acc;
        end
    end

    // Sticky out-of-range flag, cleared on entry to ARM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_range <= 1'b0;
        end else if ((r_state != S_ARM) && (w_next == S_ARM)) begin
            r_range <= 1'b0;
        end else if ((r_state == S_SAMPLE) && w_extreme) begin
            r_range <= 1'b1;
        end else begin
            r_range <= r_range;
        end
    end

    // Result register, loaded once per measurement and held until the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= {RES_W{1'b0}};
        end else if (r_state == S_CALC) begin
            r_result <= RES_W'(w_avg);
        end else begin
            r_result <= r_result;
        end
    end

    assign sensor_en_o = r_sensor_en;
    assign busy_o      = r_busy;
    assign valid_o     = r_valid;
    assign result_o    = r_result;
    assign range_o     = r_range;

endmodule
